// File: rtl/hvac_pkg.sv
// ---------------------------------------------------------------------------
// hvac_pkg
// Shared definitions for the HVAC sequencer slice: FSM state encodings,
// heat/cool mode constants, fan speed codes and a one-step fan ramp helper.
// ---------------------------------------------------------------------------
package hvac_pkg;

    localparam int STATE_W = 3;

    // Encodings are visible on the status port, so they are pinned explicitly.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_RUN     = 3'd2,
        ST_POST    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    localparam logic MODE_HEAT = 1'b0;
    localparam logic MODE_COOL = 1'b1;

    localparam logic [1:0] FAN_OFF  = 2'b00;
    localparam logic [1:0] FAN_LOW  = 2'b01;
    localparam logic [1:0] FAN_MED  = 2'b10;
    localparam logic [1:0] FAN_HIGH = 2'b11;

    // Move the fan one code toward the target, never jumping more than a step.
    function automatic logic [1:0] fan_step(input logic [1:0] cur, input logic [1:0] tgt);
        logic [1:0] nxt;
        nxt = cur;
        if (cur < tgt) begin
            nxt = cur + 2'd1;
        end else if (cur > tgt) begin
            nxt = cur - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/hvac_sequencer_if.sv
// ---------------------------------------------------------------------------
// hvac_sequencer_if
// Bundles the request side (tick strobe, heat/cool/idle requests, requested
// fan speed) and the actuator side (fan speed, element enables, state, busy).
//   master : drives tick and requests, observes actuator commands
//   slave  : the sequencer; consumes requests, drives actuator commands
// ---------------------------------------------------------------------------
interface hvac_sequencer_if;
    import hvac_pkg::*;

    logic               tick;
    logic               req_heat;
    logic               req_cool;
    logic               req_idle;
    logic [1:0]         req_speed;
    logic [1:0]         fan_speed;
    logic               heat_on;
    logic               cool_on;
    logic [STATE_W-1:0] state;
    logic               busy;

    modport master (
        output tick, req_heat, req_cool, req_idle, req_speed,
        input  fan_speed, heat_on, cool_on, state, busy
    );

    modport slave (
        input  tick, req_heat, req_cool, req_idle, req_speed,
        output fan_speed, heat_on, cool_on, state, busy
    );

endinterface

// File: rtl/hvac_tick_timer.sv
// ---------------------------------------------------------------------------
// hvac_tick_timer
// CNT_W-bit up counter advanced by a tick enable, with synchronous clear
// (clear wins over enable) and a terminal-count compare.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   clr      : return the count to zero on the next edge
//   en       : advance the count by one on the next edge
//   term     : terminal value to compare against
//   at_term  : high while the current count equals term
// ---------------------------------------------------------------------------
module hvac_tick_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             at_term
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear has priority so a state change always restarts timing.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_term = (count_q == term);

endmodule

// File: rtl/hvac_sequencer.sv
// ---------------------------------------------------------------------------
// hvac_sequencer
// Turns instantaneous heat/cool/idle/speed requests into safe actuator
// commands: fan pre-purge, minimum on-time, post-purge, off-time lockout and a
// one-step fan ramp. All timing counts ticks of bus.tick, not clock cycles.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   bus      : hvac_sequencer_if.slave (requests in, registered commands out)
// ---------------------------------------------------------------------------
module hvac_sequencer
    import hvac_pkg::*;
#(
    parameter int unsigned PRE_TICKS     = 3,
    parameter int unsigned POST_TICKS    = 5,
    parameter int unsigned MIN_ON_TICKS  = 10,
    parameter int unsigned MIN_OFF_TICKS = 8,
    parameter int unsigned RAMP_TICKS    = 2,
    parameter int          CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    hvac_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_TICKS - 1);
    localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_TICKS - 1);
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(MIN_ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(MIN_OFF_TICKS - 1);
    localparam logic [CNT_W-1:0] RAMP_LAST = CNT_W'(RAMP_TICKS - 1);

    state_t     state_q, state_d;
    logic       mode_q, mode_d;
    logic [1:0] fan_q, fan_d;
    logic       heat_q, heat_d;
    logic       cool_q, cool_d;
    logic       busy_q, busy_d;
    logic       min_met_q, min_met_d;

    logic             want_heat, want_cool, match, min_ok, ramp_due;
    logic [1:0]       target;
    logic [CNT_W-1:0] tterm;
    logic             tcnt_last, rcnt_last, tclr, ten, rclr;

    assign want_heat = bus.req_heat & ~bus.req_cool & ~bus.req_idle;
    assign want_cool = bus.req_cool & ~bus.req_heat & ~bus.req_idle;
    assign match     = (mode_q == MODE_COOL) ? want_cool : want_heat;
    assign target    = (bus.req_speed == FAN_OFF) ? FAN_LOW : bus.req_speed;
    assign ramp_due  = bus.tick & rcnt_last;

    // The minimum is met either on the tick that completes it or any time after.
    assign min_ok = min_met_q | (bus.tick & tcnt_last);

    // The state timer compares against the duration of whichever state is active.
    always_comb begin
        tterm = '0;
        case (state_q)
            ST_PRE:     tterm = PRE_LAST;
            ST_RUN:     tterm = ON_LAST;
            ST_POST:    tterm = POST_LAST;
            ST_LOCKOUT: tterm = OFF_LAST;
            default:    tterm = '0;
        endcase
    end

    // min_met_q freezes the state timer in RUN so the on-time count saturates.
    assign ten  = bus.tick & ~min_met_q;
    assign tclr = (state_d != state_q) | (state_q == ST_IDLE);
    assign rclr = (state_q != ST_RUN) | (state_d != state_q) | ramp_due;

    hvac_tick_timer #(.CNT_W(CNT_W)) u_tcnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (tclr),
        .en      (ten),
        .term    (tterm),
        .at_term (tcnt_last)
    );

    hvac_tick_timer #(.CNT_W(CNT_W)) u_rcnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (rclr),
        .en      (bus.tick),
        .term    (RAMP_LAST),
        .at_term (rcnt_last)
    );

    // Next-state and next-output decode; outputs are computed for the state
    // being entered so they update on the same edge as the state register.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        fan_d   = fan_q;
        heat_d  = heat_q;
        cool_d  = cool_q;
        case (state_q)
            ST_IDLE: begin
                fan_d  = FAN_OFF;
                heat_d = 1'b0;
                cool_d = 1'b0;
                if (want_heat | want_cool) begin
                    state_d = ST_PRE;
                    mode_d  = want_cool ? MODE_COOL : MODE_HEAT;
                    fan_d   = FAN_LOW;
                end
            end
            ST_PRE: begin
                fan_d  = FAN_LOW;
                heat_d = 1'b0;
                cool_d = 1'b0;
                // A changed request aborts the purge before the timer is considered.
                if (!match) begin
                    state_d = ST_IDLE;
                    fan_d   = FAN_OFF;
                end else if (bus.tick && tcnt_last) begin
                    state_d = ST_RUN;
                    heat_d  = (mode_q == MODE_HEAT);
                    cool_d  = (mode_q == MODE_COOL);
                end
            end
            ST_RUN: begin
                heat_d = (mode_q == MODE_HEAT);
                cool_d = (mode_q == MODE_COOL);
                if (!match && min_ok) begin
                    state_d = ST_POST;
                    fan_d   = FAN_LOW;
                    heat_d  = 1'b0;
                    cool_d  = 1'b0;
                end else if (ramp_due) begin
                    fan_d = fan_step(fan_q, target);
                end
            end
            ST_POST: begin
                fan_d  = FAN_LOW;
                heat_d = 1'b0;
                cool_d = 1'b0;
                if (bus.tick && tcnt_last) begin
                    state_d = ST_LOCKOUT;
                    fan_d   = FAN_OFF;
                end
            end
            ST_LOCKOUT: begin
                fan_d  = FAN_OFF;
                heat_d = 1'b0;
                cool_d = 1'b0;
                if (bus.tick && tcnt_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mode_d  = MODE_HEAT;
                fan_d   = FAN_OFF;
                heat_d  = 1'b0;
                cool_d  = 1'b0;
            end
        endcase
        busy_d    = (state_d != ST_IDLE);
        min_met_d = (state_q == ST_RUN) && (state_d == ST_RUN) && min_ok;
    end

    // State and registered command outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_HEAT;
            fan_q     <= FAN_OFF;
            heat_q    <= 1'b0;
            cool_q    <= 1'b0;
            busy_q    <= 1'b0;
            min_met_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            fan_q     <= fan_d;
            heat_q    <= heat_d;
            cool_q    <= cool_d;
            busy_q    <= busy_d;
            min_met_q <= min_met_d;
        end
    end

    assign bus.fan_speed = fan_q;
    assign bus.heat_on   = heat_q;
    assign bus.cool_on   = cool_q;
    assign bus.state     = state_q;
    assign bus.busy      = busy_q;

endmodule
